vn_iblut_loader: RTL and testbench

Write-side controller that fills a VN IB-LUT (the single-port, async-read IB-RAM holding the VN message mapping) with a new table from a valid/ready stream, then hands the shared address port back to the decoder for mapping reads. Sits directly upstream of the VN IB-LUT and drives its data-in, common address and active-low write-enable. One instance per VN IB-LUT, for both GP1 and GP2 configurations.

---
 rtl/memShare_ib_pkg.sv | 14 +
 rtl/ib_xor_csum.sv | 29 ++
 rtl/vn_iblut_loader.sv | 152 +++++++++++++++
 tb/tb_vn_iblut_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memShare_ib_pkg.sv
// Shared types and defaults for the VN IB-LUT loader family.
// Holds the loader FSM encoding, the default table length and the checksum width.
package memShare_ib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ib_state_t;

  localparam int VN_LOAD_CYCLE_DEF = 64;
  localparam int IB_CSUM_W         = 4;

endpackage

// File: rtl/ib_xor_csum.sv
// XOR accumulator over accepted table entries; clear has priority over enable.
// Latency: one cycle from enable to updated acc. No backpressure (always accepts).
// Only built with IB_LOADER_CHECKSUM_EN.
`ifdef IB_LOADER_CHECKSUM_EN
module ib_xor_csum
  import memShare_ib_pkg::*;
#(
  parameter int W = IB_CSUM_W
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule
`endif

// File: rtl/vn_iblut_loader.sv
// Fills a VN IB-LUT from a valid/ready stream, then returns the address port to the decoder.
// Latency: handshake -> registered write strobe next cycle; DONE 1+VN_LOAD_CYCLE cycles after start.
// Backpressure: ready only in LOAD; optional checksum ports under IB_LOADER_CHECKSUM_EN.
module vn_iblut_loader
  import memShare_ib_pkg::*;
#(
  parameter int ADDR_WIDTH    = 6,
  parameter int VN_LOAD_CYCLE = VN_LOAD_CYCLE_DEF,
  parameter int MSG_WIDTH     = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  input  logic [MSG_WIDTH-1:0]  lut_data_i,
  input  logic                  lut_valid_i,
  output logic                  lut_ready_o,
  input  logic [ADDR_WIDTH-1:0] map_addr_i,
  output logic [MSG_WIDTH-1:0]  remap_dataIn_o,
  output logic [ADDR_WIDTH-1:0] map_remap_addr_o,
  output logic                  remap_en_n_o,
  output logic                  busy_o,
  output logic                  load_done_o,
  output logic                  map_ready_o
`ifdef IB_LOADER_CHECKSUM_EN
  ,
  input  logic [MSG_WIDTH-1:0]  exp_csum_i,
  output logic                  load_err_o
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VN_LOAD_CYCLE - 1);

  ib_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [MSG_WIDTH-1:0]  wr_dat_q;
  logic                  wr_vld_q;
  logic                  map_ready_q;
  logic                  accept;
  logic                  start_load;
  logic                  csum_ok;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (load_start_i) state_d = ST_LOAD;
      ST_LOAD: if (accept && (cnt_q == LAST_IDX)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outside a load the decoder owns the address port combinationally.
  always_comb begin
    lut_ready_o      = 1'b0;
    busy_o           = 1'b0;
    load_done_o      = 1'b0;
    start_load       = 1'b0;
    map_remap_addr_o = wr_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        map_remap_addr_o = map_addr_i;
        start_load       = load_start_i;
      end
      ST_LOAD: begin
        lut_ready_o = 1'b1;
        busy_o      = 1'b1;
      end
      ST_DONE: begin
        busy_o      = 1'b1;
        load_done_o = 1'b1;
      end
      default: map_remap_addr_o = map_addr_i;
    endcase
  end

  assign accept         = lut_ready_o & lut_valid_i;
  assign remap_dataIn_o = wr_dat_q;
  assign remap_en_n_o   = ~wr_vld_q;
  assign map_ready_o    = map_ready_q;

  // The counter saturates on the last index, so it can never wrap into a rewrite.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      wr_addr_q   <= '0;
      wr_dat_q    <= '0;
      wr_vld_q    <= 1'b0;
      map_ready_q <= 1'b0;
    end else begin
      wr_vld_q <= accept;
      if (start_load) begin
        cnt_q       <= '0;
        map_ready_q <= 1'b0;
      end
      if (accept) begin
        wr_addr_q <= cnt_q;
        wr_dat_q  <= lut_data_i;
        if (cnt_q != LAST_IDX) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (load_done_o) begin
        map_ready_q <= csum_ok;
      end
    end
  end

`ifdef IB_LOADER_CHECKSUM_EN
  logic [MSG_WIDTH-1:0] exp_csum_q;
  logic [MSG_WIDTH-1:0] csum_acc;
  logic                 load_err_q;

  ib_xor_csum #(
    .W (MSG_WIDTH)
  ) u_csum (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clr     (start_load),
    .en      (accept),
    .din     (lut_data_i),
    .acc     (csum_acc)
  );

  // By DONE the accumulator already includes the final entry.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      exp_csum_q <= '0;
      load_err_q <= 1'b0;
    end else if (start_load) begin
      exp_csum_q <= exp_csum_i;
      load_err_q <= 1'b0;
    end else if (load_done_o) begin
      load_err_q <= (csum_acc != exp_csum_q);
    end
  end

  assign csum_ok    = (csum_acc == exp_csum_q);
  assign load_err_o = load_err_q;
`else
  assign csum_ok = 1'b1;
`endif

endmodule

// File: tb/tb_vn_iblut_loader.sv
// Randomized self-checking bench for vn_iblut_loader with a behavioural load model and IB-LUT.
// Checksum scenarios are included when IB_LOADER_CHECKSUM_EN is defined.
module tb_vn_iblut_loader;

  localparam int AW = 6;
  localparam int MW = 4;
  localparam int N  = 64;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic          load_start_i;
  logic [MW-1:0] lut_data_i;
  logic          lut_valid_i;
  logic          lut_ready_o;
  logic [AW-1:0] map_addr_i;
  logic [MW-1:0] remap_dataIn_o;
  logic [AW-1:0] map_remap_addr_o;
  logic          remap_en_n_o;
  logic          busy_o;
  logic          load_done_o;
  logic          map_ready_o;
`ifdef IB_LOADER_CHECKSUM_EN
  logic [MW-1:0] exp_csum_i;
  logic          load_err_o;
`endif

  vn_iblut_loader #(
    .ADDR_WIDTH    (AW),
    .VN_LOAD_CYCLE (N),
    .MSG_WIDTH     (MW)
  ) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .load_start_i     (load_start_i),
    .lut_data_i       (lut_data_i),
    .lut_valid_i      (lut_valid_i),
    .lut_ready_o      (lut_ready_o),
    .map_addr_i       (map_addr_i),
    .remap_dataIn_o   (remap_dataIn_o),
    .map_remap_addr_o (map_remap_addr_o),
    .remap_en_n_o     (remap_en_n_o),
    .busy_o           (busy_o),
    .load_done_o      (load_done_o),
    .map_ready_o      (map_ready_o)
`ifdef IB_LOADER_CHECKSUM_EN
    ,
    .exp_csum_i       (exp_csum_i),
    .load_err_o       (load_err_o)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int ready_cyc = 0;
  int wr_cnt = 0;
  logic prev_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural IB-LUT: captures whenever the write strobe is low at a clock edge.
  logic [MW-1:0] lut_mem [N];
  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    if (!rst && !remap_en_n_o) begin
      lut_mem[map_remap_addr_o] <= remap_dataIn_o;
      wr_cnt = wr_cnt + 1;
    end
  end

  // Reference model of the load protocol.
  int            m_phase = 0;   // 0 idle, 1 loading, 2 done
  int            m_n = 0;
  bit            m_wr = 0;
  logic [AW-1:0] m_wa = '0;
  logic [MW-1:0] m_wd = '0;
  bit            m_map_ready = 0;
  logic [MW-1:0] m_xor = '0;
  logic [MW-1:0] m_exp = '0;
  bit            m_err = 0;
  logic [MW-1:0] ref_mem [N];

  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_n = 0; m_wr = 0; m_wa = '0; m_wd = '0;
      m_map_ready = 0; m_xor = '0; m_exp = '0; m_err = 0;
    end else begin
      case (m_phase)
        0: begin
          m_wr = 0;
          if (load_start_i) begin
            m_phase = 1; m_n = 0; m_map_ready = 0; m_xor = '0; m_err = 0;
`ifdef IB_LOADER_CHECKSUM_EN
            m_exp = exp_csum_i;
`endif
          end
        end
        1: begin
          if (lut_valid_i) begin
            m_wr = 1;
            m_wa = AW'(m_n);
            m_wd = lut_data_i;
            ref_mem[m_n] = lut_data_i;
            m_xor = m_xor ^ lut_data_i;
            m_n++;
            if (m_n == N) m_phase = 2;
          end else begin
            m_wr = 0;
          end
        end
        default: begin
          m_wr = 0;
`ifdef IB_LOADER_CHECKSUM_EN
          m_err = (m_xor != m_exp);
`endif
          m_map_ready = !m_err;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge sys_clk) begin
    if (load_done_o === 1'b1) done_cyc = cyc;
    if (map_ready_o === 1'b1 && !prev_ready) ready_cyc = cyc;
    prev_ready = (map_ready_o === 1'b1);
    if (cyc > 0) begin
      if (rst) begin
        chk("rst_lut_ready", lut_ready_o, 0);
        chk("rst_en_n", remap_en_n_o, 1);
        chk("rst_data", remap_dataIn_o, 0);
        chk("rst_addr", map_remap_addr_o, map_addr_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", load_done_o, 0);
        chk("rst_map_ready", map_ready_o, 0);
      end else begin
        chk("lut_ready", lut_ready_o, m_phase == 1);
        chk("en_n", remap_en_n_o, !m_wr);
        chk("wr_data", remap_dataIn_o, m_wd);
        chk("addr", map_remap_addr_o, (m_phase == 0) ? map_addr_i : m_wa);
        chk("busy", busy_o, m_phase != 0);
        chk("load_done", load_done_o, m_phase == 2);
        chk("map_ready", map_ready_o, m_map_ready);
`ifdef IB_LOADER_CHECKSUM_EN
        chk("load_err", load_err_o, m_err);
`endif
      end
    end
  end

  task automatic start_load(input logic [MW-1:0] csum);
`ifdef IB_LOADER_CHECKSUM_EN
    exp_csum_i = csum;
`else
    if (csum != '0) map_addr_i = map_addr_i;
`endif
    load_start_i = 1'b1;
    start_cyc = cyc;
    @(posedge sys_clk); #1;
    load_start_i = 1'b0;
  endtask

  // mode 0: back-to-back, data = index; 1: every third cycle idle; 2: random valid, random data
  task automatic feed(input int n, input int mode, input int inj_start_at, input bit toggle_addr,
                      input int rst_at, input int flip_at);
    int  sent = 0;
    int  k = 0;
    bit  acc;
    while (sent < n && k < 4 * n + 40) begin
      if (rst_at >= 0 && sent == rst_at) begin
        lut_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge sys_clk); #1;
        rst = 1'b0;
        return;
      end
      lut_valid_i  = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 != 2) : 1'($urandom_range(0, 1));
      lut_data_i   = (mode == 0) ? sent[MW-1:0] : MW'($urandom);
      if (sent == flip_at) lut_data_i = lut_data_i ^ 4'h1;
      load_start_i = (sent == inj_start_at);
      if (toggle_addr) map_addr_i = AW'($urandom);
      @(negedge sys_clk);
      acc = lut_valid_i && lut_ready_o;
      @(posedge sys_clk); #1;
      if (acc) sent++;
      k++;
    end
    lut_valid_i  = 1'b0;
    load_start_i = 1'b0;
    if (sent < n) chk("feed_timeout", sent, n);
  endtask

  task automatic settle();
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  task automatic readback_all();
    for (int a = 0; a < N; a++) begin
      map_addr_i = AW'(a);
      #1;
      chk("readback", lut_mem[map_remap_addr_o], ref_mem[a]);
    end
  endtask

  int wr_snap;

  initial begin
    rst = 1'b1;
    load_start_i = 1'b0;
    lut_valid_i = 1'b0;
    lut_data_i = '0;
    map_addr_i = 6'h15;
`ifdef IB_LOADER_CHECKSUM_EN
    exp_csum_i = '0;
`endif
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset_en_n", remap_en_n_o, 1);
    chk("reset_addr_15", map_remap_addr_o, 6'h15);
    chk("reset_map_ready", map_ready_o, 0);
    chk("reset_lut_ready", lut_ready_o, 0);
    @(posedge sys_clk); #1;
    rst = 1'b0;
    @(posedge sys_clk); #1;

    // Back-to-back load with data = addr[3:0]
    wr_cnt = 0;
    start_load('0);
    feed(N, 0, -1, 0, -1, -1);
    settle();
    chk("a_done_latency", done_cyc - start_cyc, 65);
    chk("a_ready_after_done", ready_cyc - done_cyc, 1);
    chk("a_write_count", wr_cnt, 64);
    chk("a_map_ready", map_ready_o, 1);
    map_addr_i = 6'h2A;
    #1;
    chk("a_readback_2a", lut_mem[map_remap_addr_o], 4'hA);
    readback_all();

    // Valid gaps every third cycle
    wr_cnt = 0;
    start_load('0);
    feed(N, 1, -1, 0, -1, -1);
    settle();
    chk("b_write_count", wr_cnt, 64);
    chk("b_map_ready", map_ready_o, 1);
    readback_all();

    // Random valid, stray start at entry 10, decoder address toggling
    wr_cnt = 0;
    start_load('0);
    feed(N, 2, 10, 1, -1, -1);
    settle();
    chk("c_write_count", wr_cnt, 64);
    readback_all();

    // Reset at entry 30, then a fresh load
    start_load('0);
    feed(N, 0, -1, 0, 30, -1);
    wr_snap = wr_cnt;
    repeat (5) @(posedge sys_clk);
    #1;
    chk("d_no_writes_after_rst", wr_cnt - wr_snap, 0);
    chk("d_map_ready_low", map_ready_o, 0);
    wr_cnt = 0;
    start_load('0);
    feed(N, 2, -1, 0, -1, -1);
    settle();
    chk("d_write_count", wr_cnt, 64);
    chk("d_map_ready", map_ready_o, 1);
    readback_all();

`ifdef IB_LOADER_CHECKSUM_EN
    start_load(4'h0);
    feed(N, 0, -1, 0, -1, -1);
    settle();
    chk("e_csum_ok_err", load_err_o, 0);
    chk("e_csum_ok_ready", map_ready_o, 1);
    start_load(4'h0);
    feed(N, 0, -1, 0, -1, 5);
    settle();
    chk("e_csum_bad_err", load_err_o, 1);
    chk("e_csum_bad_ready", map_ready_o, 0);
`endif

    repeat (2) @(posedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
